// File: rtl/tplatch_bank.sv
// Bank of per-channel latches (LEVEL: transparent on eb; EDGE: shadow committed on eb fall), global lock, chg strobes, readback.
// Latency: LEVEL q is 0 cycles, EDGE q is 1 clk after the sampled fall. There is no backpressure; lock freezes every hold register.
module tplatch_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter logic [CHANNELS-1:0] EDGE_MODE = '0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       eb,
  input  logic                      lock,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] ql,
  output logic [CHANNELS-1:0]       chg,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [WIDTH-1:0]          rd_q
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OPEN = 1'b1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] d_ch;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_nxt;
    logic             chg_r;
    logic             upd;

    assign d_ch = d[i*WIDTH +: WIDTH];
    assign upd  = eb[i] & ~lock;

    if (EDGE_MODE[i]) begin : g_edge
      logic [0:0]       state;
      logic [WIDTH-1:0] shadow;

      // Commit only on a sampled fall while unlocked; a lock while OPEN drops the shadow.
      always_comb begin
        hold_nxt = hold;
        if ((state == OPEN) && !eb[i] && !lock) begin
          hold_nxt = shadow;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state  <= IDLE;
          shadow <= '0;
        end else if (upd) begin
          state  <= OPEN;
          shadow <= d_ch;
        end else begin
          state  <= IDLE;
        end
      end

      assign q[i*WIDTH +: WIDTH] = reset ? RESET_VAL : hold;
    end else begin : g_level
      always_comb begin
        hold_nxt = hold;
        if (upd) begin
          hold_nxt = d_ch;
        end
      end

      assign q[i*WIDTH +: WIDTH] = reset ? RESET_VAL : (upd ? d_ch : hold);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold  <= RESET_VAL;
        chg_r <= 1'b0;
      end else begin
        hold  <= hold_nxt;
        chg_r <= (hold_nxt != hold);
      end
    end

    assign chg[i] = chg_r;
  end

  assign ql = ~q;

  // Out-of-range selects read as zero.
  always_comb begin
    rd_q = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_q = q[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tplatch_bank.sv
// Scoreboard bench for tplatch_bank: ch0 LEVEL, ch1/ch2 EDGE, CHANNELS=3 so rd_sel=3 is out of range.
module tb_tplatch_bank;

  localparam int W  = 8;
  localparam int CH = 3;
  localparam logic [W-1:0] RV  = 8'h96;
  localparam logic [W-1:0] NRV = 8'h69;
  localparam int K_Q = 0, K_QL = 1, K_CHG = 2, K_RD = 3;

  logic            clk;
  logic            reset;
  logic [CH*W-1:0] d;
  logic [CH-1:0]   eb;
  logic            lock;
  logic [CH*W-1:0] q;
  logic [CH*W-1:0] ql;
  logic [CH-1:0]   chg;
  logic [1:0]      rd_sel;
  logic [W-1:0]    rd_q;

  tplatch_bank #(
    .WIDTH(W), .CHANNELS(CH), .EDGE_MODE(3'b110), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset(reset), .d(d), .eb(eb), .lock(lock),
    .q(q), .ql(ql), .chg(chg), .rd_sel(rd_sel), .rd_q(rd_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           kind;
    int           ch;
    logic [W-1:0] exp;
  } chk_t;

  chk_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int ch, input logic [W-1:0] v);
    d[ch*W +: W] = v;
  endtask

  task automatic ex(input string name, input int kind, input int ch, input logic [W-1:0] v);
    chk_t c;
    c.name = name; c.kind = kind; c.ch = ch; c.exp = v;
    sb.push_back(c);
  endtask

  // Monitor: every expectation queued since the last edge is checked at the falling edge.
  chk_t         cur;
  logic [W-1:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.kind)
        K_Q:     act = q[cur.ch*W +: W];
        K_QL:    act = ql[cur.ch*W +: W];
        K_CHG:   act = {{(W-CH){1'b0}}, chg};
        default: act = rd_q;
      endcase
      total++;
      if (act === cur.exp) passed++;
      else $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; eb = '0; d = '0; lock = 1'b0; rd_sel = '0;
    eb[0] = 1'b1; set_d(0, 8'hA5);
    step();
    ex("rst_q0", K_Q, 0, RV); ex("rst_ql0", K_QL, 0, NRV);
    ex("rst_q1", K_Q, 1, RV); ex("rst_chg", K_CHG, 0, 8'h00);
    step(); reset = 1'b0;
    ex("rel_q0", K_Q, 0, 8'hA5); ex("rel_chg", K_CHG, 0, 8'h00);
    step();
    ex("rel_chg_pulse", K_CHG, 0, 8'h01); ex("rel_ql0", K_QL, 0, 8'h5A);
    // LEVEL hold after close
    step(); set_d(0, 8'h3C);
    ex("lvl_q0_open", K_Q, 0, 8'h3C); ex("lvl_chg_same", K_CHG, 0, 8'h00);
    step();
    ex("lvl_chg_once", K_CHG, 0, 8'h01);
    step(); eb[0] = 1'b0; set_d(0, 8'hFF);
    ex("lvl_q0_hold", K_Q, 0, 8'h3C); ex("lvl_chg_idle", K_CHG, 0, 8'h00);
    // EDGE commit
    step(); eb[1] = 1'b1; set_d(1, 8'h11);
    ex("lvl_q0_closed", K_Q, 0, 8'h3C); ex("lvl_chg_closed", K_CHG, 0, 8'h00);
    ex("edge_q1_pre", K_Q, 1, RV);
    step(); set_d(1, 8'h22);
    ex("edge_q1_open", K_Q, 1, RV);
    step(); eb[1] = 1'b0;
    ex("edge_q1_fall", K_Q, 1, RV); ex("edge_chg_pre", K_CHG, 0, 8'h00);
    step();
    ex("edge_q1_commit", K_Q, 1, 8'h22); ex("edge_chg1", K_CHG, 0, 8'h02);
    // lock discards the pending EDGE commit and freezes LEVEL
    step(); eb[1] = 1'b1; set_d(1, 8'h77);
    ex("edge_chg_done", K_CHG, 0, 8'h00); ex("edge_q1_kept", K_Q, 1, 8'h22);
    step(); lock = 1'b1; eb[0] = 1'b1; set_d(0, 8'hEE);
    ex("lock_q0", K_Q, 0, 8'h3C); ex("lock_q1", K_Q, 1, 8'h22);
    step(); eb[1] = 1'b0;
    ex("lock_q1_b", K_Q, 1, 8'h22); ex("lock_chg", K_CHG, 0, 8'h00);
    ex("lock_q0_b", K_Q, 0, 8'h3C);
    step(); lock = 1'b0; eb[0] = 1'b0;
    ex("unlock_q1", K_Q, 1, 8'h22); ex("unlock_chg", K_CHG, 0, 8'h00);
    ex("unlock_q0", K_Q, 0, 8'h3C);
    step(); eb[2] = 1'b1; set_d(2, 8'h5A);
    ex("unlock_q1_b", K_Q, 1, 8'h22); ex("unlock_chg_b", K_CHG, 0, 8'h00);
    // reset while ch2 is OPEN
    step(); eb[2] = 1'b0; reset = 1'b1;
    ex("mid_rst_q2", K_Q, 2, RV); ex("mid_rst_q0", K_Q, 0, RV);
    ex("mid_rst_chg", K_CHG, 0, 8'h00);
    step(); reset = 1'b0;
    ex("mid_rel_q2", K_Q, 2, RV);
    step(); eb[0] = 1'b1; set_d(0, 8'hC3); eb[1] = 1'b1; set_d(1, 8'h4B);
    ex("abort_q2", K_Q, 2, RV); ex("abort_chg", K_CHG, 0, 8'h00);
    // readback and identical rewrite
    step(); eb[1] = 1'b0;
    ex("rb_chg0", K_CHG, 0, 8'h01); ex("rb_q0", K_Q, 0, 8'hC3);
    step(); eb[0] = 1'b0;
    ex("same_val_chg", K_CHG, 0, 8'h02);
    step(); rd_sel = 2'd0;
    ex("rd_sel0", K_RD, 0, 8'hC3); ex("rb_chg_idle", K_CHG, 0, 8'h00);
    step(); rd_sel = 2'd1;
    ex("rd_sel1", K_RD, 0, 8'h4B);
    step(); rd_sel = 2'd2;
    ex("rd_sel2", K_RD, 0, RV);
    step(); rd_sel = 2'd3;
    ex("rd_sel3_oob", K_RD, 0, 8'h00);
    step();
    step();
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
